// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: drives pll_areset, qualifies the synchronized lock
// indication, retries on lock timeout and holds the engine in reset until lock is stable.
module pll_lock_sequencer #(
  parameter int unsigned RESET_CYCLES        = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned LOSS_FILTER_CYCLES  = 4,
  localparam int unsigned RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic               restart_req,
  output logic               restart_ack,
  output logic               pll_areset,
  output logic               pll_ready,
  output logic               engine_hold,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_count,
  output logic [2:0]         state
);

  localparam int unsigned RC_W = $clog2(RESET_CYCLES + 1);
  localparam int unsigned ST_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned TO_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int unsigned LS_W = $clog2(LOSS_FILTER_CYCLES + 1);

  localparam logic [RC_W-1:0]    RC_LAST   = RC_W'(RESET_CYCLES - 1);
  localparam logic [ST_W-1:0]    ST_LAST   = ST_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [LS_W-1:0]    LS_LAST   = LS_W'(LOSS_FILTER_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         sync_q;
  logic               lock_s;
  logic [RC_W-1:0]    rc_q, rc_d;
  logic [ST_W-1:0]    st_q, st_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [LS_W-1:0]    loss_q, loss_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               ack_q, ack_d;

  assign lock_s = sync_q[1];

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      state_q <= S_RESET;
      rc_q    <= '0;
      st_q    <= '0;
      to_q    <= '0;
      loss_q  <= '0;
      retry_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], pll_locked};
      state_q <= state_d;
      rc_q    <= rc_d;
      st_q    <= st_d;
      to_q    <= to_d;
      loss_q  <= loss_d;
      retry_q <= retry_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    st_d    = st_q;
    to_d    = to_q;
    loss_d  = loss_q;
    retry_d = retry_q;
    ack_d   = restart_req;

    if (restart_req) begin
      state_d = S_RESET;
      rc_d    = '0;
      st_d    = '0;
      to_d    = '0;
      loss_d  = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        S_RESET: begin
          to_d = '0;
          if (rc_q >= RC_LAST) begin
            rc_d    = '0;
            state_d = S_WAIT_LOCK;
          end else begin
            rc_d = rc_q + 1'b1;
          end
        end
        S_WAIT_LOCK, S_STABLE: begin
          to_d = (to_q == '1) ? to_q : to_q + 1'b1;
          // Timeout is tested first so it wins over a same-cycle promotion to RUN.
          if (to_q >= TO_LAST) begin
            to_d = '0;
            st_d = '0;
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 1'b1;
              state_d = S_RESET;
            end else begin
              state_d = S_FAULT;
            end
          end else if (!lock_s) begin
            st_d    = '0;
            state_d = S_WAIT_LOCK;
          end else if (state_q == S_WAIT_LOCK) begin
            st_d    = ST_W'(1);
            state_d = S_STABLE;
          end else if (st_q >= ST_LAST) begin
            st_d    = '0;
            loss_d  = '0;
            retry_d = '0;
            state_d = S_RUN;
          end else begin
            st_d = st_q + 1'b1;
          end
        end
        S_RUN: begin
          if (lock_s) begin
            loss_d = '0;
          end else if (loss_q >= LS_LAST) begin
            loss_d  = '0;
            state_d = S_RESET;
          end else begin
            loss_d = loss_q + 1'b1;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_RESET;
        end
      endcase
    end
  end

  assign pll_areset  = (state_q == S_RESET);
  assign pll_ready   = (state_q == S_RUN);
  assign engine_hold = (state_q != S_RUN);
  assign fault       = (state_q == S_FAULT);
  assign restart_ack = ack_q;
  assign retry_count = retry_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed vector table, hand-written reset
// sequence, then random lock/restart stimulus against an attempt-level model.
module tb_pll_lock_sequencer;

  localparam int RC  = 4;
  localparam int LSC = 8;
  localparam int LTC = 32;
  localparam int MR  = 2;
  localparam int LFC = 3;

  logic       clk_in = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       restart_req = 1'b0;
  logic       restart_ack, pll_areset, pll_ready, engine_hold, fault;
  logic [1:0] retry_count;
  logic [2:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  pll_lock_sequencer #(
    .RESET_CYCLES(RC),
    .LOCK_STABLE_CYCLES(LSC),
    .LOCK_TIMEOUT_CYCLES(LTC),
    .MAX_RETRIES(MR),
    .LOSS_FILTER_CYCLES(LFC)
  ) dut (
    .clk_in(clk_in),
    .reset_n(reset_n),
    .pll_locked(pll_locked),
    .restart_req(restart_req),
    .restart_ack(restart_ack),
    .pll_areset(pll_areset),
    .pll_ready(pll_ready),
    .engine_hold(engine_hold),
    .fault(fault),
    .retry_count(retry_count),
    .state(state)
  );

  always #5 clk_in = ~clk_in;

  // Attempt-level reference: age within the current phase, length of the
  // current run of synced-high samples, and length of the low run in RUN.
  int   m_state, m_age, m_hi, m_lo, m_retry;
  bit   m_ack;
  bit [1:0] m_sync;

  task automatic model_reset();
    m_state = 0; m_age = 0; m_hi = 0; m_lo = 0; m_retry = 0; m_ack = 0; m_sync = '0;
  endtask

  task automatic model_step(input bit req, input bit lk);
    bit ls;
    ls     = m_sync[1];
    m_sync = {m_sync[0], lk};
    m_ack  = req;
    if (req) begin
      m_state = 0; m_age = 0; m_hi = 0; m_lo = 0; m_retry = 0;
    end else if (m_state == 0) begin
      m_age++;
      if (m_age == RC) begin m_state = 1; m_age = 0; m_hi = 0; end
    end else if (m_state == 1 || m_state == 2) begin
      m_age++;
      m_hi = ls ? m_hi + 1 : 0;
      if (m_age == LTC) begin
        m_age = 0; m_hi = 0;
        if (m_retry < MR) begin m_retry++; m_state = 0; end
        else m_state = 4;
      end else if (m_hi == LSC) begin
        m_state = 3; m_retry = 0; m_lo = 0;
      end else begin
        m_state = (m_hi > 0) ? 2 : 1;
      end
    end else if (m_state == 3) begin
      m_lo = ls ? 0 : m_lo + 1;
      if (m_lo == LFC) begin m_state = 0; m_age = 0; m_lo = 0; end
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    if (reset_n) model_step(restart_req, pll_locked);
    else model_reset();
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] es, input logic eack,
                       input logic [1:0] eret);
    logic [9:0] exp, act;
    exp = {es, es == 3'd0, es == 3'd3, es != 3'd3, es == 3'd4, eack, eret};
    act = {state, pll_areset, pll_ready, engine_hold, fault, restart_ack, retry_count};
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got st=%0d areset=%b ready=%b hold=%b fault=%b ack=%b retry=%0d, expected st=%0d areset=%b ready=%b hold=%b fault=%b ack=%b retry=%0d",
                  name, act[9:7], act[6], act[5], act[4], act[3], act[2], act[1:0],
                  exp[9:7], exp[6], exp[5], exp[4], exp[3], exp[2], exp[1:0]);
  endtask

  typedef struct {
    bit req;
    bit lk;
    int n;
    int st;
    bit ack;
    int rt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit req, input bit lk, input int n, input int st,
                     input bit ack, input int rt);
    vec_t v;
    v.req = req; v.lk = lk; v.n = n; v.st = st; v.ack = ack; v.rt = rt;
    tbl.push_back(v);
  endtask

  initial begin
    int seg;
    // nominal bring-up: areset 4 cycles, lock raised 5 cycles into WAIT_LOCK
    add(0,0,3,0,0,0); add(0,0,1,1,0,0); add(0,0,4,1,0,0);
    add(0,1,2,1,0,0); add(0,1,1,2,0,0); add(0,1,6,2,0,0); add(0,1,1,3,0,0);
    // lock loss: two low samples tolerated, three drop to RESET
    add(0,0,2,3,0,0); add(0,1,4,3,0,0); add(0,0,4,3,0,0); add(0,0,1,0,0,0);
    // glitchy lock: 5 high, 1 low, then high
    add(0,0,3,0,0,0); add(0,0,1,1,0,0); add(0,1,2,1,0,0); add(0,1,3,2,0,0);
    add(0,0,1,2,0,0); add(0,1,1,2,0,0); add(0,1,1,1,0,0); add(0,1,1,2,0,0);
    add(0,1,6,2,0,0); add(0,1,1,3,0,0);
    // restart from RUN, then never locks: three attempts into FAULT
    add(1,0,1,0,1,0); add(0,0,1,0,0,0); add(0,0,3,1,0,0);
    add(0,0,31,1,0,0); add(0,0,1,0,0,1); add(0,0,3,0,0,1); add(0,0,1,1,0,1);
    add(0,0,31,1,0,1); add(0,0,1,0,0,2); add(0,0,4,1,0,2);
    add(0,0,31,1,0,2); add(0,0,1,4,0,2); add(0,0,200,4,0,2);
    // restart out of FAULT, full areset
    add(1,0,1,0,1,0); add(0,0,3,0,0,0); add(0,0,1,1,0,0);
    // restart on the timeout cycle wins
    add(0,0,31,1,0,0); add(1,0,1,0,1,0); add(0,0,3,0,0,0); add(0,0,1,1,0,0);

    model_reset();
    repeat (3) tick();
    check("reset_state", 3'd0, 1'b0, 2'd0);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      restart_req = tbl[i].req;
      pll_locked  = tbl[i].lk;
      for (int c = 0; c < tbl[i].n; c++) begin
        tick();
        restart_req = 1'b0;
      end
      check($sformatf("row%0d", i), 3'(tbl[i].st), tbl[i].ack, 2'(tbl[i].rt));
    end

    // async reset while in STABLE, then clean restart with lock already high
    restart_req = 1'b1; tick(); restart_req = 1'b0;
    repeat (4) tick();
    pll_locked = 1'b1;
    repeat (4) tick();
    check("pre_async_stable", 3'd2, 1'b0, 2'd0);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check("async_reset_now", 3'd0, 1'b0, 2'd0);
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    check("after_rst_wait", 3'd1, 1'b0, 2'd0);
    tick();
    check("after_rst_stable", 3'd2, 1'b0, 2'd0);
    repeat (6) tick();
    check("after_rst_still_stable", 3'd2, 1'b0, 2'd0);
    tick();
    check("after_rst_run", 3'd3, 1'b0, 2'd0);

    // random lock behaviour and occasional restarts versus the model
    reset_n = 1'b0; pll_locked = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    seg = 3;
    for (int c = 0; c < 4000; c++) begin
      if (seg == 0) begin
        pll_locked = ~pll_locked;
        if (pll_locked) seg = $urandom_range(4, 40);
        else seg = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 80) : $urandom_range(1, 5);
      end
      seg--;
      restart_req = ($urandom_range(0, 299) == 0);
      tick();
      restart_req = 1'b0;
      check("random", 3'(m_state), m_ack, 2'(m_retry));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences bring-up of the fractal engine's clock PLL.
- Drives the PLL areset, filters and qualifies the PLL locked indication, and retries on lock timeout.
- Holds the fractal engine in reset until the PLL output clock is stable, and handles lock loss and software restart.
- Runs on the board reference clock (the PLL input clock, 50 MHz); outputs feed the PLL instance and the engine reset synchronizer.

Parameters:
RESET_CYCLES, 16, cycles pll_areset is held high per attempt (>=1)
LOCK_STABLE_CYCLES, 1024, consecutive synced-lock-high cycles required before ready (>=1)
LOCK_TIMEOUT_CYCLES, 65536, max cycles from leaving RESET to reaching RUN before the attempt fails (> LOCK_STABLE_CYCLES)
MAX_RETRIES, 3, failed attempts retried before FAULT (>=0)
LOSS_FILTER_CYCLES, 4, consecutive synced-lock-low cycles in RUN that count as lock loss (>=1)

Ports:
clk_in  input  1  reference clock; all logic on rising edge
reset_n  input  1  asynchronous active-low reset
pll_locked  input  1  PLL locked, asynchronous to clk_in
restart_req  input  1  single-cycle restart request
restart_ack  output  1  one-cycle pulse acknowledging restart_req
pll_areset  output  1  PLL asynchronous reset, active-high
pll_ready  output  1  high only in RUN
engine_hold  output  1  engine reset request, active-high; low only in RUN
fault  output  1  high only in FAULT
retry_count  output  $clog2(MAX_RETRIES+1) (min 1)  failed attempts since last RUN or restart
state  output  3  RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4

Behaviour:
- pll_locked passes through a 2-flop synchronizer to give lock_s. Both flops reset to 0. No other logic uses pll_locked.
- Reset (reset_n low):
  - state=RESET, all counters 0.
  - Outputs: pll_areset=1, engine_hold=1, pll_ready=0, fault=0, restart_ack=0, retry_count=0.
- All outputs are registered and decoded from the state register.
- RESET:
  - pll_areset=1 for exactly RESET_CYCLES cycles, then go to WAIT_LOCK.
  - The timeout counter clears on exit.
- WAIT_LOCK:
  - Timeout counter increments each cycle.
  - lock_s=1 -> STABLE, with the stable counter at 1.
- STABLE:
  - Timeout counter keeps incrementing.
  - lock_s=1 increments the stable counter. When it reaches LOCK_STABLE_CYCLES -> RUN.
  - lock_s=0 -> WAIT_LOCK; the stable counter clears.
- Timeout: the timeout counter reaches LOCK_TIMEOUT_CYCLES in WAIT_LOCK or STABLE.
  - If retry_count < MAX_RETRIES: retry_count+1, go to RESET.
  - Otherwise go to FAULT.
  - Timeout takes priority over the STABLE->RUN transition in the same cycle.
- RUN:
  - pll_ready=1, engine_hold=0. retry_count clears on entry.
  - Loss counter counts consecutive lock_s=0 cycles and clears on lock_s=1.
  - At LOSS_FILTER_CYCLES -> RESET. Lock loss does not increment retry_count.
  - engine_hold rises in the same cycle pll_ready falls.
- FAULT:
  - pll_areset=0, engine_hold=1, fault=1.
  - Sticky; exited only by restart_req or reset_n.
- restart_req, in any state:
  - Next state is RESET; all counters and retry_count clear.
  - restart_ack=1 in the cycle after the request cycle.
  - Has priority over timeout, lock loss and STABLE->RUN in the same cycle.
  - restart_req while already in RESET restarts the RESET_CYCLES count.
- Counters saturate, never wrap. Counter widths are sized from the parameters via $clog2.

Test Plan:
Use RESET_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2, LOSS_FILTER_CYCLES=3.
- Nominal bring-up: release reset_n, raise pll_locked 5 cycles after pll_areset falls -> pll_areset high exactly 4 cycles; state passes 0->1->2->3; pll_ready and engine_hold toggle together exactly 10 cycles after pll_locked rises (2 sync + 8 stable).
- Glitchy lock: pll_locked high 5 cycles, low 1 cycle, then high -> state returns 2->1->2; pll_ready 10 cycles after the final rise; no timeout.
- Never locks: pll_locked held 0 -> three attempts, retry_count 0,1,2; then state=4, fault=1, pll_areset=0, engine_hold=1; stays there 200 cycles.
- Lock loss in RUN:
  - pll_locked low 2 cycles -> stays RUN.
  - pll_locked low 3 cycles -> state=0, pll_ready=0, engine_hold=1, retry_count stays 0.
- Restart from FAULT, and restart_req coinciding with a timeout cycle -> restart_ack one cycle later; state=0; retry_count=0; full 4-cycle areset.
- Async reset asserted mid-STABLE -> outputs immediately at reset values; sequence restarts cleanly after release.
